// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RV32I-style ALU with registered result and flags.
//
// Each operation is accepted with a valid/ready handshake. The result
// and flags are presented with another valid/ready handshake. Most
// ops complete in one cycle. Shifts move one bit per cycle. MUL uses
// N shift-add iterations.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   in_valid     operands/opcode valid
//   in_ready     high while idle; an op is accepted on in_valid && in_ready
//   reg_source1  operand A
//   reg_source2  operand B (shift amount = low SW bits)
//   alucontrol   opcode (0..C legal, D..F illegal)
//   carry_in     carry / no-borrow input for ADDC and SUBB
//   out_valid    result valid (held until out_ready)
//   out_ready    consumer accepts the result
//   reg_destiny  result
//   zero         result == 0
//   negative     result MSB
//   carry_out    add carry / subtract no-borrow
//   overflow     signed overflow for add/sub ops
//   illegal      unsupported opcode
//
// FSM states:
//   state | meaning
//   IDLE  | waiting for an operation; in_ready high
//   SHIFT | iterative shift, one bit per cycle
//   MUL   | iterative shift-add multiply
//   DONE  | result valid; waiting for out_ready

module alu_mc #(
    parameter int N = 32,
    localparam int SW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] reg_source1,
    input  logic [N-1:0] reg_source2,
    input  logic [3:0]   alucontrol,
    input  logic         carry_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] reg_destiny,
    output logic         zero,
    output logic         negative,
    output logic         carry_out,
    output logic         overflow,
    output logic         illegal
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_MUL   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_SLTU = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_SRL  = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'h9;
    localparam logic [3:0] OP_ADDC = 4'hA;
    localparam logic [3:0] OP_SUBB = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [3:0]    op_q;
    logic [N-1:0]  work;      // shift value or multiply accumulator
    logic [N-1:0]  mcand;     // multiplicand, shifted left each iteration
    logic [N-1:0]  mplier;    // multiplier, shifted right each iteration
    logic [SW-1:0] cnt;

    logic [SW-1:0] shamt;
    logic          accept;
    logic          is_shift;

    logic [N-1:0]  b_eff;
    logic          cin_eff;
    logic [N:0]    sum;
    logic          sum_ovf;

    // Result and flags to register when the FSM enters DONE this cycle.
    logic          fin;
    logic [N-1:0]  fin_r;
    logic          fin_c;
    logic          fin_o;
    logic          fin_i;
    logic [N-1:0]  step;

    function automatic logic [N-1:0] shift1(input logic [N-1:0] v,
                                            input logic [3:0] op);
        logic [N-1:0] r;
        case (op)
            OP_SLL:  r = {v[N-2:0], 1'b0};
            OP_SRA:  r = {v[N-1], v[N-1:1]};
            default: r = {1'b0, v[N-1:1]};
        endcase
        return r;
    endfunction

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign shamt    = reg_source2[SW-1:0];
    assign is_shift = (alucontrol == OP_SLL) || (alucontrol == OP_SRL) ||
                      (alucontrol == OP_SRA);

    // Shared N+1 bit adder. Subtraction is A + ~B + cin. The overflow test
    // "same sign into the adder, different sign out" then covers both
    // add and subtract forms.
    always_comb begin
        b_eff   = reg_source2;
        cin_eff = 1'b0;
        case (alucontrol)
            OP_SUB:  begin b_eff = ~reg_source2; cin_eff = 1'b1;     end
            OP_SUBB: begin b_eff = ~reg_source2; cin_eff = carry_in; end
            OP_ADDC: cin_eff = carry_in;
            default: ;
        endcase
        sum     = {1'b0, reg_source1} + {1'b0, b_eff} + {{N{1'b0}}, cin_eff};
        sum_ovf = (reg_source1[N-1] == b_eff[N-1]) &&
                  (sum[N-1] != reg_source1[N-1]);
    end

    always_comb begin
        state_nxt = state;
        fin       = 1'b0;
        fin_r     = '0;
        fin_c     = 1'b0;
        fin_o     = 1'b0;
        fin_i     = 1'b0;
        step      = '0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    if (is_shift) begin
                        // The accept edge already applies the first bit,
                        // so a shift by shamt takes shamt cycles in total.
                        if (shamt == '0) begin
                            fin   = 1'b1;
                            fin_r = reg_source1;
                        end else if (shamt == SW'(1)) begin
                            fin   = 1'b1;
                            fin_r = shift1(reg_source1, alucontrol);
                        end else begin
                            state_nxt = S_SHIFT;
                        end
                    end else if (alucontrol == OP_MUL) begin
                        state_nxt = S_MUL;
                    end else begin
                        fin = 1'b1;
                        case (alucontrol)
                            OP_ADD, OP_SUB, OP_ADDC, OP_SUBB: begin
                                fin_r = sum[N-1:0];
                                fin_c = sum[N];
                                fin_o = sum_ovf;
                            end
                            OP_AND:  fin_r = reg_source1 & reg_source2;
                            OP_OR:   fin_r = reg_source1 | reg_source2;
                            OP_XOR:  fin_r = reg_source1 ^ reg_source2;
                            OP_SLT:  fin_r = {{(N-1){1'b0}},
                                              $signed(reg_source1) < $signed(reg_source2)};
                            OP_SLTU: fin_r = {{(N-1){1'b0}}, reg_source1 < reg_source2};
                            default: fin_i = 1'b1;
                        endcase
                    end
                end
            end
            S_SHIFT: begin
                step = shift1(work, op_q);
                if (cnt == SW'(1)) begin
                    fin   = 1'b1;
                    fin_r = step;
                end
            end
            S_MUL: begin
                step = work + (mplier[0] ? mcand : '0);
                if (cnt == SW'(1)) begin
                    fin   = 1'b1;
                    fin_r = step;
                end
            end
            default: begin
                if (out_ready) state_nxt = S_IDLE;
            end
        endcase
        if (fin) state_nxt = S_DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_q        <= '0;
            work        <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
            out_valid   <= 1'b0;
            reg_destiny <= '0;
            zero        <= 1'b0;
            negative    <= 1'b0;
            carry_out   <= 1'b0;
            overflow    <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                op_q <= alucontrol;
                if (is_shift) begin
                    work <= shift1(reg_source1, alucontrol);
                    cnt  <= shamt - SW'(1);
                end else if (alucontrol == OP_MUL) begin
                    // First shift-add iteration happens on the accept edge.
                    work   <= reg_source2[0] ? reg_source1 : '0;
                    mcand  <= {reg_source1[N-2:0], 1'b0};
                    mplier <= {1'b0, reg_source2[N-1:1]};
                    cnt    <= SW'(N - 1);
                end
            end else if (state == S_SHIFT || state == S_MUL) begin
                work   <= step;
                mcand  <= {mcand[N-2:0], 1'b0};
                mplier <= {1'b0, mplier[N-1:1]};
                cnt    <= cnt - SW'(1);
            end

            if (fin) begin
                out_valid   <= 1'b1;
                reg_destiny <= fin_r;
                zero        <= (fin_r == '0);
                negative    <= fin_r[N-1];
                carry_out   <= fin_c;
                overflow    <= fin_o;
                illegal     <= fin_i;
            end else if (state == S_DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] reg_source1 = '0;
    logic [31:0] reg_source2 = '0;
    logic [3:0]  alucontrol = '0;
    logic        carry_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] reg_destiny;
    logic        zero, negative, carry_out, overflow, illegal;

    int checks = 0;
    int errors = 0;

    alu_mc #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .reg_source1(reg_source1), .reg_source2(reg_source2),
        .alucontrol(alucontrol), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .reg_destiny(reg_destiny), .zero(zero), .negative(negative),
        .carry_out(carry_out), .overflow(overflow), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flags packed as {zero, negative, carry_out, overflow, illegal}.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic cin, input int exp_lat,
                          input logic [31:0] exp_r, input logic [4:0] exp_f);
        int lat;
        bit busy_ok;
        @(negedge clk);
        check({tag, " in_ready"}, in_ready, 1);
        reg_source1 = a;
        reg_source2 = b;
        alucontrol  = op;
        carry_in    = cin;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the result must not depend on them.
        in_valid    = 1'b0;
        reg_source1 = $urandom;
        reg_source2 = $urandom;
        alucontrol  = 4'h0;
        carry_in    = ~cin;
        lat = 1;
        busy_ok = 1'b1;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy"}, busy_ok, 1);
        check({tag, " result"}, reg_destiny, exp_r);
        check({tag, " flags"}, {zero, negative, carry_out, overflow, illegal}, exp_f);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, " drop"}, {out_valid, in_ready}, 2'b01);
        out_ready = 1'b0;
    endtask

    initial begin
        bit quiet;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", {out_valid, in_ready, reg_destiny, zero, negative, carry_out, overflow, illegal},
              {1'b0, 1'b1, 32'h0, 5'b0});
        rst_n = 1'b1;

        run_op("add_ovf", 32'h7FFFFFFF, 32'h1, 4'h0, 1'b0, 1, 32'h80000000, 5'b01010); release_out("add_ovf");
        run_op("add_lo",  32'hFFFFFFFF, 32'h1, 4'h0, 1'b0, 1, 32'h0,        5'b10100); release_out("add_lo");
        run_op("addc_hi", 32'h1,        32'h0, 4'hA, 1'b1, 1, 32'h2,        5'b00000); release_out("addc_hi");
        run_op("add_cin", 32'h1,        32'h1, 4'h0, 1'b1, 1, 32'h2,        5'b00000); release_out("add_cin");
        run_op("add_neg", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h0, 1'b0, 1, 32'hFFFFFFFE, 5'b01100); release_out("add_neg");

        // Backpressure: result held while a competing op is presented.
        run_op("sub_bp", 32'h5, 32'h7, 4'h1, 1'b0, 1, 32'hFFFFFFFE, 5'b01000);
        for (int i = 0; i < 10; i++) begin
            reg_source1 = 32'h3;
            reg_source2 = 32'h4;
            alucontrol  = 4'h0;
            in_valid    = 1'b1;
            @(negedge clk);
            check("sub_bp hold", {out_valid, in_ready, reg_destiny, carry_out},
                  {1'b1, 1'b0, 32'hFFFFFFFE, 1'b0});
        end
        in_valid = 1'b0;
        release_out("sub_bp");

        run_op("sub_ovf",  32'h80000000, 32'h1, 4'h1, 1'b0, 1, 32'h7FFFFFFF, 5'b00110); release_out("sub_ovf");
        run_op("subb_brw", 32'h0,        32'h0, 4'hB, 1'b0, 1, 32'hFFFFFFFF, 5'b01000); release_out("subb_brw");
        run_op("subb_nb",  32'h5,        32'h3, 4'hB, 1'b1, 1, 32'h2,        5'b00100); release_out("subb_nb");
        run_op("and", 32'hF0F0F0F0, 32'hFF00FF00, 4'h2, 1'b0, 1, 32'hF000F000, 5'b01000); release_out("and");
        run_op("or",  32'hF0F0F0F0, 32'hFF00FF00, 4'h3, 1'b0, 1, 32'hFFF0FFF0, 5'b01000); release_out("or");
        run_op("xor", 32'hF0F0F0F0, 32'hFF00FF00, 4'h4, 1'b0, 1, 32'h0FF00FF0, 5'b00000); release_out("xor");
        run_op("slt",  32'hFFFFFFFF, 32'h1, 4'h5, 1'b0, 1, 32'h1, 5'b00000); release_out("slt");
        run_op("sltu", 32'hFFFFFFFF, 32'h1, 4'h6, 1'b0, 1, 32'h0, 5'b10000); release_out("sltu");
        run_op("sll4", 32'h1,        32'h24, 4'h7, 1'b0, 4, 32'h10,       5'b00000); release_out("sll4");
        run_op("srl1", 32'h80000000, 32'h1,  4'h8, 1'b0, 1, 32'h40000000, 5'b00000); release_out("srl1");
        run_op("srl2", 32'hF0000000, 32'h2,  4'h8, 1'b0, 2, 32'h3C000000, 5'b00000); release_out("srl2");
        run_op("sra31", 32'h80000000, 32'h3F, 4'h9, 1'b0, 31, 32'hFFFFFFFF, 5'b01000); release_out("sra31");
        run_op("sra0",  32'h80000000, 32'h20, 4'h9, 1'b0, 1,  32'h80000000, 5'b01000); release_out("sra0");
        run_op("mul_a", 32'h0000FFFF, 32'h00010001, 4'hC, 1'b0, 32, 32'hFFFFFFFF, 5'b01000); release_out("mul_a");
        run_op("mul_b", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hC, 1'b0, 32, 32'h1,        5'b00000); release_out("mul_b");
        run_op("mul_c", 32'h3,        32'h5,        4'hC, 1'b0, 32, 32'hF,        5'b00000); release_out("mul_c");
        run_op("ill_d", 32'h1234,     32'h5678,     4'hD, 1'b0, 1,  32'h0,        5'b10001); release_out("ill_d");
        run_op("mul_d", 32'h0000FFFF, 32'h00010001, 4'hC, 1'b0, 32, 32'hFFFFFFFF, 5'b01000); release_out("mul_d");

        // Reset in the middle of a multiply discards it.
        @(negedge clk);
        reg_source1 = 32'h0000FFFF;
        reg_source2 = 32'h00010001;
        alucontrol  = 4'hC;
        in_valid    = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_reset", {out_valid, in_ready, reg_destiny, zero, negative, carry_out, overflow, illegal},
              {1'b0, 1'b1, 32'h0, 5'b0});
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) quiet = 1'b0;
        end
        check("mid_reset quiet", quiet, 1);
        run_op("ill_e", 32'hFFFF, 32'h1, 4'hE, 1'b0, 1, 32'h0, 5'b10001); release_out("ill_e");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
